// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with a locked grant: one requester owns the shared
// resource until done_i or until the hold timer forces release.
module rr_lock_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = (NUM_REQ == 1) ? 1 : $clog2(NUM_REQ),
    parameter int MAX_HOLD  = 256,
    parameter int CNT_WIDTH = $clog2(MAX_HOLD + 1)
) (
    input  logic                 clk_i,
    input  logic                 arst_ni,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic                 done_i,
    output logic [NUM_REQ-1:0]   gnt_o,
    output logic [IDX_WIDTH-1:0] gnt_idx_o,
    output logic                 busy_o,
    output logic                 timeout_o
);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e                 state_q, state_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic [IDX_WIDTH-1:0]   ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   timeout_q, timeout_d;

    logic                   pick_valid;
    logic [IDX_WIDTH-1:0]   pick_idx;
    logic [IDX_WIDTH-1:0]   cand;
    logic [NUM_REQ-1:0]     pick_onehot;
    logic [IDX_WIDTH-1:0]   ptr_wrap;
    logic                   hold_expired;

    // Scan offsets from highest to lowest so the requester closest to ptr wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDX_WIDTH'((int'(ptr_q) + k) % NUM_REQ);
            if (req_i[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign pick_onehot[gi] = (pick_idx == IDX_WIDTH'(gi));
        end
    endgenerate

    assign ptr_wrap     = (int'(idx_q) == NUM_REQ - 1) ? '0 : idx_q + 1'b1;
    assign hold_expired = (cnt_q == CNT_WIDTH'(MAX_HOLD - 1));

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = BUSY;
                    gnt_d   = pick_onehot;
                    idx_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                // done_i has priority over the timeout on the same edge.
                if (done_i || hold_expired) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    idx_d     = '0;
                    ptr_d     = ptr_wrap;
                    timeout_d = ~done_i;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            idx_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign gnt_idx_o = idx_q;
    assign busy_o    = (state_q == BUSY);
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Scoreboard bench for rr_lock_arbiter: a transaction-level model predicts
// grants and releases; a negedge monitor compares what the DUT presents.
module tb_rr_lock_arbiter;

    localparam int N  = 4;
    localparam int MH = 8;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          arst_ni = 1'b0;
    logic [N-1:0]  req_i = '0;
    logic          done_i = 1'b0;
    logic [N-1:0]  gnt_o;
    logic [IW-1:0] gnt_idx_o;
    logic          busy_o;
    logic          timeout_o;

    always #5 clk = ~clk;

    rr_lock_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
        .clk_i     (clk),
        .arst_ni   (arst_ni),
        .req_i     (req_i),
        .done_i    (done_i),
        .gnt_o     (gnt_o),
        .gnt_idx_o (gnt_idx_o),
        .busy_o    (busy_o),
        .timeout_o (timeout_o)
    );

    typedef struct {
        int dur;   // -1: released by reset, duration not checked
        bit to;
    } rel_t;

    int   checks = 0;
    int   errors = 0;
    int   gnt_exp[$];
    rel_t rel_exp[$];
    int   obs[$];
    int   to_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: the lock/rotate rules at transaction level.
    bit m_busy;
    int m_ptr, m_idx, m_hold;
    initial begin
        m_busy = 0; m_ptr = 0; m_idx = 0; m_hold = 0;
        forever begin
            @(posedge clk);
            if (!arst_ni) begin
                if (m_busy) rel_exp.push_back('{-1, 1'b0});
                m_busy = 0; m_ptr = 0; m_hold = 0;
            end else if (!m_busy) begin
                if (req_i != 0) begin
                    for (int k = N - 1; k >= 0; k--)
                        if (req_i[(m_ptr + k) % N]) m_idx = (m_ptr + k) % N;
                    gnt_exp.push_back(m_idx);
                    m_busy = 1; m_hold = 0;
                end
            end else if (done_i) begin
                rel_exp.push_back('{m_hold + 1, 1'b0});
                m_busy = 0; m_ptr = (m_idx + 1) % N;
            end else if (m_hold == MH - 1) begin
                rel_exp.push_back('{MH, 1'b1});
                m_busy = 0; m_ptr = (m_idx + 1) % N;
            end else begin
                m_hold++;
            end
        end
    end

    // Monitor: invariants every cycle, grant/release events against the queues.
    initial begin
        logic [N-1:0] prev;
        int high;
        int enc;
        int e;
        rel_t r;
        prev = '0;
        high = 0;
        forever begin
            @(negedge clk);
            enc = 0;
            for (int i = 0; i < N; i++) if (gnt_o[i]) enc = i;
            chk("onehot", $onehot0(gnt_o), 1);
            chk("idx_enc", gnt_idx_o, enc);
            chk("busy", busy_o, gnt_o != 0);
            if (timeout_o) to_seen++;
            if (gnt_o != 0 && prev == 0) begin
                high = 1;
                if (gnt_exp.size() == 0) begin
                    chk("unexpected_grant", gnt_o, 0);
                end else begin
                    e = gnt_exp.pop_front();
                    chk("grant_idx", gnt_idx_o, e);
                    chk("grant_vec", gnt_o, 1 << e);
                    obs.push_back(int'(gnt_idx_o));
                end
            end else if (gnt_o != 0) begin
                high++;
                chk("grant_frozen", gnt_o, prev);
            end
            if (gnt_o == 0 && prev != 0) begin
                if (rel_exp.size() == 0) begin
                    chk("unexpected_release", 1, 0);
                end else begin
                    r = rel_exp.pop_front();
                    chk("release_timeout", timeout_o, r.to);
                    if (r.dur >= 0) chk("grant_duration", high, r.dur);
                end
            end else begin
                chk("timeout_idle", timeout_o, 0);
            end
            prev = gnt_o;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_grant(input string name);
        int n;
        n = 0;
        while (gnt_o == 0 && n < 40) begin
            step();
            n++;
        end
        if (gnt_o == 0) chk({name, "_wait"}, 0, 1);
    endtask

    task automatic pulse_done();
        done_i = 1'b1;
        step();
        done_i = 1'b0;
    endtask

    task automatic check_obs(input string name, input int base, input int n, input logic [31:0] exp);
        chk({name, "_count"}, obs.size() - base, n);
        for (int i = 0; i < n; i++)
            if (base + i < obs.size()) chk({name, "_seq"}, obs[base + i], exp[4*i +: 4]);
    endtask

    initial begin
        int base;
        int to0;

        // Reset held with all requests high.
        req_i = 4'b1111;
        arst_ni = 1'b0;
        repeat (3) step();
        chk("rst_gnt", gnt_o, 0);
        chk("rst_idx", gnt_idx_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_timeout", timeout_o, 0);

        // Fairness: 0,1,2,3,0,1.
        base = obs.size();
        arst_ni = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_grant("fair");
            pulse_done();
        end
        check_obs("fair", base, 6, 32'h103210);

        // Lock on idx 2 while requests change underneath.
        req_i = 4'b0100;
        base = obs.size();
        wait_grant("lock");
        req_i = 4'b0000;
        repeat (2) step();
        req_i = 4'b0001;
        repeat (5) step();
        chk("lock_hold", gnt_o, 4'b0100);
        pulse_done();
        wait_grant("lock_next");
        req_i = 4'b0000;
        pulse_done();
        check_obs("lock", base, 2, 32'h02);

        // Partial requests from a fresh pointer: 1,3,1.
        arst_ni = 1'b0;
        step();
        arst_ni = 1'b1;
        base = obs.size();
        req_i = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            wait_grant("part");
            pulse_done();
        end
        req_i = 4'b0000;
        check_obs("part", base, 3, 32'h131);

        // Hold timeout, then done_i on the last allowed cycle.
        base = obs.size();
        to0 = to_seen;
        req_i = 4'b0100;
        wait_grant("tmo1");
        req_i = 4'b0000;
        repeat (MH + 3) step();
        chk("tmo_pulse", to_seen - to0, 1);
        req_i = 4'b1000;
        wait_grant("tmo2");
        req_i = 4'b0000;
        repeat (MH - 1) step();
        pulse_done();
        repeat (2) step();
        chk("tmo_done_wins", to_seen - to0, 1);
        check_obs("tmo", base, 2, 32'h32);

        // Reset in the middle of a grant on idx 3.
        base = obs.size();
        req_i = 4'b1000;
        wait_grant("mid");
        repeat (2) step();
        arst_ni = 1'b0;
        #1;
        chk("mid_rst_gnt", gnt_o, 0);
        chk("mid_rst_idx", gnt_idx_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_timeout", timeout_o, 0);
        req_i = 4'b1111;
        step();
        arst_ni = 1'b1;
        wait_grant("mid_after");
        req_i = 4'b0000;
        pulse_done();
        check_obs("mid", base, 2, 32'h03);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            req_i   = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            done_i  = ($urandom_range(0, 5) == 0);
            arst_ni = ($urandom_range(0, 149) != 0);
            step();
        end

        arst_ni = 1'b1;
        req_i = 4'b0000;
        pulse_done();
        repeat (3) step();
        chk("drain_grants", gnt_exp.size(), 0);
        chk("drain_releases", rel_exp.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_lock_arbiter.md
Name: rr_lock_arbiter

Overview:
- Round-robin arbiter that shares one resource (e.g. the UART TX path or the AXI response channel) among NUM_REQ requesters.
- Produces a registered one-hot grant and the matching binary index, so downstream muxes select directly.
- Each grant is locked until the resource signals transaction completion, or until a hold timeout forces release.
- Sits between per-source request logic and the shared datapath mux.

Parameters:
NUM_REQ, 4, number of requesters (>=1)
IDX_WIDTH, NUM_REQ==1 ? 1 : $clog2(NUM_REQ), width of binary grant index
MAX_HOLD, 256, maximum cycles a grant may stay locked without done_i (>=2)
CNT_WIDTH, $clog2(MAX_HOLD+1), width of hold counter

Ports:
clk_i  input  1  clock, all state on rising edge
arst_ni  input  1  asynchronous active-low reset
req_i  input  NUM_REQ  per-requester request level
done_i  input  1  shared resource finished current transaction; sampled only while busy_o=1
gnt_o  output  NUM_REQ  registered one-hot grant, all-zero when idle
gnt_idx_o  output  IDX_WIDTH  binary index of granted requester; 0 when idle
busy_o  output  1  a grant is active (state BUSY)
timeout_o  output  1  one-cycle pulse: last grant was force-released by the hold timeout

Behaviour:
- Reset (arst_ni=0, asynchronous): gnt_o=0, gnt_idx_o=0, busy_o=0, timeout_o=0, state=IDLE, priority pointer ptr=0, hold_cnt=0.
- Release from reset is synchronous to clk_i; the first arbitration happens at the first rising edge with arst_ni=1.
- State IDLE:
  - At each edge, if req_i!=0, grant the first set bit scanning ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1.
  - Load gnt_o and gnt_idx_o, set busy_o=1, hold_cnt=0, go to BUSY.
  - If req_i==0, stay in IDLE with outputs at zero.
- Latency: a request visible before edge n gives gnt_o high after edge n, i.e. one cycle.
- State BUSY: gnt_o and gnt_idx_o are frozen and req_i is ignored. The grant stays even if the holder deasserts its request. At each edge:
  - done_i=1: go to IDLE, clear gnt_o, gnt_idx_o and busy_o; set ptr=(gnt_idx+1) mod NUM_REQ.
  - else if hold_cnt==MAX_HOLD-1: same release and pointer update, and set timeout_o=1 for exactly the next cycle.
  - else: hold_cnt increments by 1.
- Grant duration: the grant is held for at least 1 cycle and at most MAX_HOLD cycles.
- done_i coincident with the timeout edge: done wins, no timeout_o pulse.
- Back-to-back: at least one IDLE cycle (gnt_o=0) separates consecutive grants. This is a guaranteed bubble that downstream muxes rely on.
- NUM_REQ==1: the pointer is always 0 and gnt_idx_o is always 0.
- Invariants:
  - gnt_o is always zero or exactly one-hot.
  - gnt_idx_o always equals the binary encoding of gnt_o.
  - busy_o == (gnt_o != 0).
- done_i while IDLE is ignored.
- Reset mid-grant: outputs clear immediately and asynchronously, ptr returns to 0, and no timeout pulse is produced.

Test Plan:
- Reset: assert arst_ni=0 while driving req_i=4'b1111 -> gnt_o=0, gnt_idx_o=0, busy_o=0, timeout_o=0. After release, first grant is 4'b0001.
- Partial requests, NUM_REQ=4: req_i=4'b1010 held, done_i pulsed once per grant:
  - gnt_o sequence is 4'b0010 (idx 1), bubble, 4'b1000 (idx 3), bubble, 4'b0010.
  - Each grant appears one cycle after entering IDLE with requests.
- Fairness: req_i=4'b1111 held, done_i pulsed one cycle after each grant -> indices 0,1,2,3,0,1. No requester is granted twice before all others are granted once.
- Lock: granted idx 2; req_i drops to 0, then req_i=4'b0001 for 5 cycles -> gnt_o stays 4'b0100 until done_i. Next grant is idx 0.
- Timeout, MAX_HOLD=8: hold a grant without done_i -> gnt_o is high for exactly 8 cycles, then gnt_o=0 and timeout_o=1 for one cycle; ptr advances.
  - Repeat with done_i=1 on the 8th cycle -> release with timeout_o=0.
- Mid-grant reset: during BUSY on idx 3, pulse arst_ni low for 1 cycle -> gnt_o=0 immediately. After release with req_i=4'b1111, the grant is idx 0.
